dbg_bridge_uart_tx: RTL and testbench
=====================================

# dbg_bridge_uart_tx

UART 8N1 transmitter for the debug bridge response path. It drains bytes from the outbound byte FIFO through that FIFO's head-of-queue interface (`data`/`valid`/`pop`) and serialises each byte onto the host UART TX line. It is the consuming end of the bridge byte FIFO on the transmit side. It supports back-to-back frames with no idle gap whenever the FIFO stays non-empty.

## Interface
Parameters:
- `BIT_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 2 to 2^DIV_W-1.
- `DIV_W`, default 16: width of the bit-period counter.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, asynchronous, active-low.
- `data_i`, input, 8: byte at the FIFO head. Valid only while `valid_i`=1.
- `valid_i`, input, 1: FIFO non-empty.
- `pop_o`, output, 1: single-cycle consume strobe. The FIFO advances its head on the same rising edge.
- `tx_o`, output, 1: serial line. Idle high. Registered.
- `busy_o`, output, 1: 1 while a frame is in progress (state ≠ IDLE).

## Operation
- States:
  - IDLE: `tx_o`=1.
  - START: `tx_o`=0, one bit period.
  - DATA: 8 bits, LSB first, one bit period each.
  - STOP: `tx_o`=1, one bit period.
- Internal registers:
  - `div_q` (DIV_W): counts down from BIT_DIV-1 to 0. `bit_end` = (`div_q`==0).
  - `bit_q` (3 bits): data bit index.
  - `shift_q` (8 bits): holds the byte being sent.
- Load condition: `load` = `valid_i` & (IDLE | (STOP & `bit_end`)).
- `pop_o` = `rst_i` & `load`. It is combinational, so the FIFO head is consumed on the same edge that captures `data_i` into `shift_q`.
- On load:
  - `shift_q` ← `data_i`
  - state ← START
  - `tx_o` ← 0
  - `div_q` ← BIT_DIV-1
- Transitions, all taken at `bit_end`:
  - START→DATA: `tx_o` ← `shift_q[0]`, `bit_q` ← 0.
  - DATA:
    - If `bit_q`≠7: shift `shift_q` right, `tx_o` ← next bit, `bit_q`+1.
    - If `bit_q`=7: go to STOP, `tx_o` ← 1.
  - STOP:
    - If `load`: go to START (back-to-back).
    - Otherwise: go to IDLE.
- `div_q` reloads to BIT_DIV-1 at every `bit_end`. Otherwise it decrements. It holds in IDLE.
- `data_i` is sampled only on the load edge. Later changes to `data_i` or `valid_i` do not affect the frame in flight.
- `valid_i`=0 in IDLE: the block stays in IDLE, `pop_o`=0, `tx_o`=1.
- `valid_i` falling mid-frame has no effect. `pop_o` is never asserted outside the load condition.
- Reset values: state=IDLE, `tx_o`=1, `busy_o`=0, `pop_o`=0, `div_q`=0, `bit_q`=0, `shift_q`=0.
- Reset mid-frame: `tx_o` returns high asynchronously and the partial byte is discarded; it is not re-popped. After release, the first frame starts cleanly from IDLE.

## Timing
- Load edge to `tx_o` falling (start bit): 1 cycle. `tx_o` goes low on the load edge itself.
- Each bit lasts exactly BIT_DIV cycles. A frame is 10×BIT_DIV cycles.
- Isolated byte: `busy_o` is high for 10×BIT_DIV cycles, starting the cycle after the pop.
- Back-to-back bytes: pops are spaced exactly 10×BIT_DIV cycles apart, with no idle cycle between the stop bit and the next start bit.
- From IDLE: pop occurs in the first cycle `valid_i`=1 (zero wait).
- `pop_o` is never high for two consecutive cycles (requires BIT_DIV ≥ 2).

## Test plan
All scenarios use BIT_DIV=4.
- **Reset:** hold `rst_i`=0 with `valid_i`=1 → `tx_o`=1, `busy_o`=0, `pop_o`=0. After release with `valid_i`=1, `pop_o` pulses in the first cycle.
- **Single byte 0xA5:** → one `pop_o` pulse. `tx_o` shows 0,1,0,1,0,0,1,0,1,1, each level 4 cycles wide (40 cycles total), then stays 1. `busy_o` is high for exactly 40 cycles.
- **Back-to-back 0x00 then 0xFF, `valid_i` held high:**
  - → second `pop_o` exactly 40 cycles after the first.
  - → `tx_o` stop bit (4 cycles high) is followed immediately by start bit low. Line = 0, 0×8, 1, 0, 1×8, 1.
  - → `busy_o` never drops between the frames.
- **Idle FIFO:** `valid_i`=0 for 100 cycles, then 1 → no `pop_o` and `tx_o`=1 throughout the idle period. The frame starts on the edge after `valid_i` rises.
- **Input changes mid-frame:** toggle `data_i` and `valid_i` during the frame → transmitted bits match the byte captured at pop, with no extra `pop_o`.
- **Reset mid-frame:** assert reset during data bit 3 of 0x3C → `tx_o`=1 immediately (asynchronous), `busy_o`=0. After release with 0x81 presented, a full 0x81 frame is sent and the 0x3C frame is not resumed.

Source files
------------

// File: rtl/dbg_bridge_uart_tx.sv
// dbg_bridge_uart_tx
// UART 8N1 transmitter that drains the outbound debug-bridge byte FIFO.
// A byte is popped from the FIFO head on the same edge that latches it into
// the shift register. The start bit drives the line on that same edge.
// While the FIFO stays non-empty, frames run back-to-back with no idle gap.
module dbg_bridge_uart_tx #(
    parameter int BIT_DIV = 868,
    parameter int DIV_W   = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       pop_o,
    output logic       tx_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

    state_t           state_r;
    state_t           state_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_s;
    logic [2:0]       bit_r;
    logic [2:0]       bit_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic             tx_r;
    logic             tx_s;
    logic             bit_end_s;
    logic             load_s;

    assign bit_end_s = (div_r == DIV_ZERO);
    // A new byte is taken when idle, or at the very end of a stop bit.
    assign load_s    = valid_i & ((state_r == ST_IDLE) |
                                  ((state_r == ST_STOP) & bit_end_s));
    // Gated by reset so the FIFO is never consumed while the bridge is held in reset.
    assign pop_o     = rst_i & load_s;
    assign tx_o      = tx_r;
    assign busy_o    = (state_r != ST_IDLE);

    // Next-state, bit timing and line level for the frame sequencer.
    always_comb begin
        state_s = state_r;
        div_s   = div_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        tx_s    = tx_r;

        if (state_r == ST_IDLE) begin
            div_s = div_r;
        end else if (bit_end_s) begin
            div_s = DIV_LOAD;
        end else begin
            div_s = div_r - DIV_ONE;
        end

        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    shift_s = data_i;
                    state_s = ST_START;
                    tx_s    = 1'b0;
                    div_s   = DIV_LOAD;
                end else begin
                    tx_s    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    tx_s    = shift_r[0];
                    bit_s   = 3'd0;
                end else begin
                    tx_s    = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_r != 3'd7) begin
                        shift_s = {1'b0, shift_r[7:1]};
                        tx_s    = shift_r[1];
                        bit_s   = bit_r + 3'd1;
                    end else begin
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end
                end else begin
                    tx_s = tx_r;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (load_s) begin
                        shift_s = data_i;
                        state_s = ST_START;
                        tx_s    = 1'b0;
                        div_s   = DIV_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                        tx_s    = 1'b1;
                    end
                end else begin
                    tx_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                tx_s    = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset forces the line high and drops any partial byte.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
            div_r   <= DIV_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
        end
    end

endmodule

// File: tb/tb_dbg_bridge_uart_tx.sv
// Testbench for dbg_bridge_uart_tx with BIT_DIV=4.
// A frame-level model (byte + cycle offset into the frame) predicts
// tx_o/busy_o/pop_o every cycle. Directed sequences pin line patterns and
// timing with hand-written constants.
module tb_dbg_bridge_uart_tx;

    localparam int BD    = 4;
    localparam int FRAME = 10 * BD;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b1;
    logic [7:0] data_i  = 8'h00;
    logic       valid_i = 1'b0;
    logic       pop_o;
    logic       tx_o;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: whether a frame is in flight, its byte, and the cycle offset within it.
    logic       m_active = 1'b0;
    logic [7:0] m_byte   = 8'h00;
    int         m_k      = 0;

    dbg_bridge_uart_tx #(.BIT_DIV(BD), .DIV_W(16)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .pop_o   (pop_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Line level for cycle k of a frame carrying byte b: start, 8 data bits LSB first, stop.
    function automatic logic level(input logic [7:0] b, input int k);
        int idx;
        idx = k / BD;
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    function automatic logic model_pop();
        return rst_i & valid_i & (!m_active || (m_k == FRAME - 1));
    endfunction

    // Advance the model one clock; a pop starts a fresh frame at offset 0.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_active <= 1'b0;
            m_k      <= 0;
        end else if (valid_i && (!m_active || (m_k == FRAME - 1))) begin
            m_active <= 1'b1;
            m_byte   <= data_i;
            m_k      <= 0;
        end else if (m_active) begin
            if (m_k == FRAME - 1) m_active <= 1'b0;
            else m_k <= m_k + 1;
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk_i) begin
        chk("model_tx", tx_o, m_active ? level(m_byte, m_k) : 1'b1);
        chk("model_busy", busy_o, m_active);
        chk("model_pop", pop_o, model_pop());
    end

    // Called just after a load edge: check 40 line levels, busy width, no extra pop, then idle.
    task automatic check_frame(input string nm, input logic [9:0] line);
        int busy_cnt;
        int pop_cnt;
        logic exp;
        busy_cnt = 0;
        pop_cnt  = 0;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(negedge clk_i);
            exp = (i < FRAME) ? line[i / BD] : 1'b1;
            chk(nm, tx_o, exp);
            if (busy_o) busy_cnt++;
            if (pop_o) pop_cnt++;
        end
        chk_int({nm, "_busy"}, busy_cnt, FRAME);
        chk_int({nm, "_pops"}, pop_cnt, 0);
    endtask

    initial begin
        int n;
        int drops;
        int bad;
        int pops;

        // Reset held with a non-empty FIFO.
        valid_i = 1'b1;
        data_i  = 8'h11;
        #1 rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("rst_tx", tx_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_pop", pop_o, 1'b0);
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(negedge clk_i);
        chk("rel_pop", pop_o, 1'b1);
        @(posedge clk_i); #1 valid_i = 1'b0;
        repeat (45) @(posedge clk_i);

        // Single byte 0xA5.
        #1 valid_i = 1'b1; data_i = 8'hA5;
        @(negedge clk_i);
        chk("a5_pop", pop_o, 1'b1);
        @(posedge clk_i); #1 valid_i = 1'b0; data_i = 8'(($urandom));
        check_frame("a5_line", 10'b11_0100_1010);

        // Back-to-back 0x00 then 0xFF with valid held high.
        @(posedge clk_i); #1 valid_i = 1'b1; data_i = 8'h00;
        @(negedge clk_i);
        chk("b2b_pop1", pop_o, 1'b1);
        @(posedge clk_i); #1 data_i = 8'hFF;
        n = 0;
        drops = 0;
        do begin
            @(negedge clk_i);
            n++;
            if (!busy_o) drops++;
        end while (!pop_o && n < 200);
        chk_int("b2b_gap", n, FRAME);
        chk_int("b2b_busy_drop", drops, 0);
        @(posedge clk_i); #1 valid_i = 1'b0;
        repeat (45) @(posedge clk_i);

        // Idle FIFO for 100 cycles, then a byte appears.
        bad = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (pop_o || !tx_o) bad++;
        end
        chk_int("idle_quiet", bad, 0);
        @(posedge clk_i); #1 valid_i = 1'b1; data_i = 8'(($urandom));
        @(negedge clk_i);
        chk("idle_pop", pop_o, 1'b1);

        // Toggle inputs during the frame; only the captured byte goes out and nothing is popped.
        @(posedge clk_i);
        pops = 0;
        for (int i = 0; i < FRAME - 2; i++) begin
            #1 valid_i = 1'($urandom); data_i = 8'(($urandom));
            @(negedge clk_i);
            if (pop_o) pops++;
            @(posedge clk_i);
        end
        #1 valid_i = 1'b0;
        chk_int("midframe_pops", pops, 0);
        repeat (50) @(posedge clk_i);

        // Randomised traffic, checked by the model alone.
        for (int i = 0; i < 400; i++) begin
            #1 valid_i = ($urandom_range(0, 3) != 0);
            data_i = 8'(($urandom));
            @(posedge clk_i);
        end
        #1 valid_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (busy_o && n < 100);
        chk("drain_idle", busy_o, 1'b0);

        // Reset during data bit 3 of 0x3C, then a clean 0x81 frame.
        @(posedge clk_i); #1 valid_i = 1'b1; data_i = 8'h3C;
        @(posedge clk_i); #1 valid_i = 1'b0; data_i = 8'h81;
        repeat (17) @(posedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        chk("mid_rst_tx", tx_o, 1'b1);
        chk("mid_rst_busy", busy_o, 1'b0);
        valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_pop", pop_o, 1'b1);
        @(posedge clk_i); #1 valid_i = 1'b0;
        check_frame("x81_line", 10'b11_0000_0010);

        repeat (5) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
